// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle RV64 subset controller.
//   - controller state enum
//   - supported opcode values
//   - ALUControl codes (also consumed by ALU_TOP)
//   - mux select encodings for result, src_a and src_b
//   - opcode classification used by the ALU control decoder
package ctrl_pkg;

    // Datapath width; informational only, no controller port depends on it.
    localparam int unsigned XLEN = 64;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StError
    } state_e;

    // Supported opcodes (IR[6:0])
    localparam logic [6:0] OP_LD     = 7'b0000011;
    localparam logic [6:0] OP_SD     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALUControl codes
    localparam logic [2:0] ALU_IDLE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_EQ   = 3'b101;
    localparam logic [2:0] ALU_NE   = 3'b110;

    // result_src encodings
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // src_a_sel encodings
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    // src_b_sel encodings
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_EIGHT = 2'b10;

    // Instruction class as seen by the ALU control decoder
    typedef enum logic [1:0] {
        ClsNone,
        ClsR,
        ClsI,
        ClsBr
    } alu_cls_e;

    function automatic alu_cls_e opcode_class(input logic [6:0] op);
        case (op)
            OP_RTYPE:  return ClsR;
            OP_IALU:   return ClsI;
            OP_BRANCH: return ClsBr;
            default:   return ClsNone;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational ALU operation decoder.
// Ports:
//   cls         in  instruction class derived from opcode
//   funct3      in  IR[14:12]
//   funct7b5    in  IR[30], selects sub for R-type funct3 000
//   alu_control out ALUControl code for the execute/compare state
//   legal       out 0 when funct3 is not supported for this class
module alu_ctrl_dec
    import ctrl_pkg::*;
(
    input  alu_cls_e   cls,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_control,
    output logic       legal
);

    always_comb begin
        alu_control = ALU_ADD;
        legal       = 1'b1;
        case (cls)
            ClsR: begin
                case (funct3)
                    3'b000:  alu_control = funct7b5 ? ALU_SUB : ALU_ADD;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: begin
                        alu_control = ALU_IDLE;
                        legal       = 1'b0;
                    end
                endcase
            end
            ClsI: begin
                case (funct3)
                    3'b000:  alu_control = ALU_ADD;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: begin
                        alu_control = ALU_IDLE;
                        legal       = 1'b0;
                    end
                endcase
            end
            ClsBr: begin
                case (funct3)
                    3'b000:  alu_control = ALU_EQ;
                    3'b001:  alu_control = ALU_NE;
                    default: begin
                        alu_control = ALU_IDLE;
                        legal       = 1'b0;
                    end
                endcase
            end
            default: begin
                // ld/sd/jal/unknown: address arithmetic only, funct3 not checked here
                alu_control = ALU_ADD;
                legal       = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style controller for the multicycle RV64 subset core.
// Sequences the shared ALU, register file, IR and unified memory.
// Ports:
//   clk, reset               rising-edge clock, async active-high reset
//   opcode/funct3/funct7b5   registered IR fields, valid from DECODE onward
//   cmp_true                 ALUResult[0] during BRANCH
//   mem_ready                memory access completes this cycle
//   pc_write, adr_src, mem_write, mem_req, ir_write   datapath strobes/selects
//   result_src, src_a_sel, src_b_sel                  datapath mux selects
//   reg_write, ALUControl                             regfile write, ALU op
//   instr_done               one-cycle pulse on the last state of an instruction
//   illegal_instr            sticky, set on entry to ERROR, cleared by reset
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       cmp_true,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       mem_req,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] src_a_sel,
    output logic [1:0] src_b_sel,
    output logic       reg_write,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal_instr
);

    state_e     state_q, state_d;
    logic       illegal_q;
    alu_cls_e   op_cls;
    logic [2:0] op_alu;
    logic       op_legal;

    assign op_cls = opcode_class(opcode);

    alu_ctrl_dec u_alu_ctrl_dec (
        .cls         (op_cls),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (op_alu),
        .legal       (op_legal)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OP_LD, OP_SD: state_d = StMemAdr;
                    OP_RTYPE:     state_d = op_legal ? StExecR  : StError;
                    OP_IALU:      state_d = op_legal ? StExecI  : StError;
                    OP_BRANCH:    state_d = op_legal ? StBranch : StError;
                    OP_JAL:       state_d = StJal;
                    default:      state_d = StError;
                endcase
            end
            StMemAdr:   state_d = (opcode == OP_LD) ? StMemRead : StMemWrite;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecR,
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJal:      state_d = StAluWb;
            StError:    state_d = StError;
            default:    state_d = StError;  // unused encodings park safely
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == StError) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Output decode: purely from state and IR fields, except the mem_ready
    // and cmp_true terms noted below.
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        mem_req    = 1'b0;
        ir_write   = 1'b0;
        result_src = RES_ALUOUT;
        src_a_sel  = SRCA_PC;
        src_b_sel  = SRCB_REGB;
        reg_write  = 1'b0;
        ALUControl = ALU_IDLE;
        instr_done = 1'b0;
        case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                src_a_sel  = SRCA_PC;
                src_b_sel  = SRCB_EIGHT;
                ALUControl = ALU_ADD;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            StDecode: begin
                src_a_sel  = SRCA_OLDPC;
                src_b_sel  = SRCB_IMM;
                ALUControl = ALU_ADD;
            end
            StMemAdr: begin
                src_a_sel  = SRCA_REGA;
                src_b_sel  = SRCB_IMM;
                ALUControl = ALU_ADD;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            StMemWb: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StMemWrite: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                // Only the completing cycle is the last cycle of the store
                instr_done = mem_ready;
            end
            StExecR: begin
                src_a_sel  = SRCA_REGA;
                src_b_sel  = SRCB_REGB;
                ALUControl = op_alu;
            end
            StExecI: begin
                src_a_sel  = SRCA_REGA;
                src_b_sel  = SRCB_IMM;
                ALUControl = op_alu;
            end
            StAluWb: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                src_a_sel  = SRCA_REGA;
                src_b_sel  = SRCB_REGB;
                ALUControl = op_alu;
                result_src = RES_ALUOUT;
                pc_write   = cmp_true;
                instr_done = 1'b1;
            end
            StJal: begin
                src_a_sel  = SRCA_OLDPC;
                src_b_sel  = SRCB_EIGHT;
                ALUControl = ALU_ADD;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
            end
            default: ;  // ERROR: everything stays 0
        endcase
    end

    assign illegal_instr = illegal_q;

endmodule
